// File: rtl/dct_2d_seq.sv
// Sequencer for a row/column 2-D DCT: generates the stage advance enables,
// fill/drain bookkeeping and output block framing around two 1-D DCTs and a transpose buffer.
module dct_2d_seq #(
    parameter int N       = 8,
    parameter int DCT_LAT = 48,
    parameter int TRB_LAT = 64,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      flush,
    output logic                      in_ready,
    output logic                      ena1,
    output logic                      trb_ena,
    output logic                      ena2,
    output logic                      out_valid,
    output logic                      out_sob,
    output logic [2*$clog2(N)-1:0]    out_idx,
    output logic                      busy,
    output logic [1:0]                state
);

    localparam int L     = 2 * DCT_LAT + TRB_LAT;
    localparam int IDX_W = 2 * $clog2(N);

    localparam logic [CNT_W-1:0] L_C     = CNT_W'(L);
    localparam logic [CNT_W-1:0] LAST_DC = CNT_W'(L - 1);
    localparam logic [CNT_W-1:0] TRB_ON  = CNT_W'(DCT_LAT);
    localparam logic [CNT_W-1:0] ENA2_ON = CNT_W'(DCT_LAT + TRB_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                st_q, st_d;
    logic [CNT_W-1:0]      fc_q, fc_d;
    logic [CNT_W-1:0]      dc_q, dc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  advance;

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= IDLE;
            fc_q  <= '0;
            dc_q  <= '0;
            idx_q <= '0;
        end else begin
            st_q  <= st_d;
            fc_q  <= fc_d;
            dc_q  <= dc_d;
            idx_q <= idx_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        advance   = (st_q == DRAIN) || in_valid;
        ena1      = advance;
        trb_ena   = advance && (fc_q >= TRB_ON);
        ena2      = advance && (fc_q >= ENA2_ON);
        out_valid = advance && (fc_q == L_C);
        out_sob   = out_valid && (idx_q == '0);

        st_d  = st_q;
        fc_d  = fc_q;
        dc_d  = dc_q;
        idx_d = idx_q;

        if (advance && (fc_q != L_C)) fc_d = fc_q + CNT_W'(1);
        // N*N is a power of two, so the index wraps to 0 by plain overflow.
        if (out_valid) idx_d = idx_q + IDX_W'(1);

        unique case (st_q)
            IDLE: begin
                if (in_valid) st_d = FILL;
            end
            FILL: begin
                if (flush)                          st_d = DRAIN;
                else if (advance && fc_q == L_C)    st_d = RUN;
            end
            RUN: begin
                if (flush) st_d = DRAIN;
            end
            DRAIN: begin
                if (dc_q == LAST_DC) begin
                    st_d  = IDLE;
                    fc_d  = '0;
                    dc_d  = '0;
                    idx_d = '0;
                end else begin
                    dc_d = dc_q + CNT_W'(1);
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign in_ready = (st_q != DRAIN);
    assign busy     = (st_q != IDLE);
    assign out_idx  = idx_q;
    assign state    = st_q;

endmodule

// File: tb/tb_dct_2d_seq.sv
// Directed self-checking bench for dct_2d_seq with N=2, DCT_LAT=2, TRB_LAT=3 (L=7).
module tb_dct_2d_seq;

    localparam int N       = 2;
    localparam int DCT_LAT = 2;
    localparam int TRB_LAT = 3;
    localparam int CNT_W   = 4;
    localparam int L       = 7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic       clk = 1'b0;
    logic       rst, in_valid, flush;
    logic       in_ready, ena1, trb_ena, ena2, out_valid, out_sob, busy;
    logic [1:0] out_idx;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    dct_2d_seq #(.N(N), .DCT_LAT(DCT_LAT), .TRB_LAT(TRB_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
        .in_ready(in_ready), .ena1(ena1), .trb_ena(trb_ena), .ena2(ena2),
        .out_valid(out_valid), .out_sob(out_sob), .out_idx(out_idx),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change just after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {ena1,trb_ena,ena2,out_valid,out_sob}, state, out_idx and {busy,in_ready}.
    task automatic cmp_all(input string tag, input int cyc, input logic [4:0] exp_en,
                           input logic [1:0] exp_st, input logic [1:0] exp_idx,
                           input logic [1:0] exp_br);
        n_cmp++;
        if ({ena1, trb_ena, ena2, out_valid, out_sob} !== exp_en) begin
            n_bad++;
            $display("FAIL %s cyc=%0d enables got=%b want=%b", tag, cyc,
                     {ena1, trb_ena, ena2, out_valid, out_sob}, exp_en);
        end
        n_cmp++;
        if (state !== exp_st) begin
            n_bad++;
            $display("FAIL %s cyc=%0d state got=%0d want=%0d", tag, cyc, state, exp_st);
        end
        n_cmp++;
        if (out_idx !== exp_idx) begin
            n_bad++;
            $display("FAIL %s cyc=%0d out_idx got=%0d want=%0d", tag, cyc, out_idx, exp_idx);
        end
        n_cmp++;
        if ({busy, in_ready} !== exp_br) begin
            n_bad++;
            $display("FAIL %s cyc=%0d busy/in_ready got=%b want=%b", tag, cyc,
                     {busy, in_ready}, exp_br);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; flush = 1'b1;
        tick();
        @(negedge clk);
        cmp_all("reset_hold", 0, 5'b00000, S_IDLE, 2'd0, 2'b01);
        tick();
        rst = 1'b0; flush = 1'b0;
        @(negedge clk);
        cmp_all("reset_after", 1, 5'b00000, S_IDLE, 2'd0, 2'b01);
        tick();
    endtask

    // Continuous in_valid from IDLE: timeline of a fresh fill.
    task automatic run_cont(input string tag, input int ncyc);
        logic [4:0] e;
        logic [1:0] s;
        logic [1:0] ix;
        for (int c = 0; c < ncyc; c++) begin
            in_valid = 1'b1;
            e  = {1'b1, c >= 2, c >= 5, c >= 7, (c >= 7) && ((c - 7) % 4 == 0)};
            s  = (c == 0) ? S_IDLE : (c <= 7) ? S_FILL : S_RUN;
            ix = (c >= 7) ? 2'((c - 7) % 4) : 2'd0;
            @(negedge clk);
            cmp_all(tag, c, e, s, ix, {c != 0, 1'b1});
            tick();
        end
    endtask

    task automatic test_fill();
        run_cont("fill", 20);
    endtask

    // After 20 cycles out_idx sits at (20-7)%4 = 1.
    task automatic test_stall();
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b0;
            @(negedge clk);
            cmp_all("stall", c, 5'b00000, S_RUN, 2'd1, 2'b11);
            tick();
        end
        in_valid = 1'b1;
        @(negedge clk);
        cmp_all("stall_resume", 3, 5'b11110, S_RUN, 2'd1, 2'b11);
        tick();
    endtask

    // Flush with a sample in RUN; fc saturated so all 7 drain cycles emit.
    task automatic test_flush_run();
        int pulses;
        logic [1:0] ix;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        cmp_all("flush_run", 0, 5'b11110, S_RUN, 2'd2, 2'b11);
        tick();
        flush = 1'b0;
        pulses = 0;
        ix = 2'd3;
        for (int i = 0; i < L; i++) begin
            in_valid = (i < 6);
            @(negedge clk);
            cmp_all("drain_full", i, {4'b1111, ix == 2'd0}, S_DRAIN, ix, 2'b10);
            if (out_valid === 1'b1) pulses++;
            ix = ix + 2'd1;
            tick();
        end
        n_cmp++;
        if (pulses != 7) begin
            n_bad++;
            $display("FAIL drain_full_pulses got=%0d want=7", pulses);
        end
        in_valid = 1'b0;
        @(negedge clk);
        cmp_all("drain_full_end", 0, 5'b00000, S_IDLE, 2'd0, 2'b01);
        tick();
        flush = 1'b1;
        @(negedge clk);
        cmp_all("flush_idle", 0, 5'b00000, S_IDLE, 2'd0, 2'b01);
        tick();
        flush = 1'b0;
        @(negedge clk);
        cmp_all("flush_idle_after", 1, 5'b00000, S_IDLE, 2'd0, 2'b01);
        tick();
    endtask

    // Three samples, then flush: only the last three drain cycles emit, idx 0,1,2.
    task automatic test_drain_partial();
        int pulses;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        cmp_all("partial_flush", 0, 5'b00000, S_FILL, 2'd0, 2'b11);
        tick();
        flush = 1'b0;
        pulses = 0;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            cmp_all("drain_part", i, {2'b11, i >= 2, i >= 4, i == 4}, S_DRAIN,
                    (i >= 4) ? 2'(i - 4) : 2'd0, 2'b10);
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 3) begin
            n_bad++;
            $display("FAIL drain_part_pulses got=%0d want=3", pulses);
        end
        @(negedge clk);
        cmp_all("drain_part_end", 0, 5'b00000, S_IDLE, 2'd0, 2'b01);
        tick();
    endtask

    // Reset in the middle of a drain, with in_valid and flush also high.
    task automatic test_reset_drain();
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (state !== S_DRAIN) begin
            n_bad++;
            $display("FAIL rst_drain_pre state got=%0d want=%0d", state, S_DRAIN);
        end
        tick();
        rst = 1'b1; in_valid = 1'b1; flush = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        cmp_all("rst_drain_post", 0, 5'b00000, S_IDLE, 2'd0, 2'b01);
        tick();
        run_cont("refill", 9);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        test_reset();
        test_fill();
        test_stall();
        test_flush_run();
        test_drain_partial();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dct_2d_seq.md
DCT_2D_SEQ -- requirements
Module: dct_2d_seq

Interface
REQ-001 Parameter N, default 8, transform block dimension; SHALL be a power of two >= 2.
REQ-002 Parameter DCT_LAT, default 48, latency in advance cycles of one 1-D DCT stage; SHALL be >= 1.
REQ-003 Parameter TRB_LAT, default 64, latency in advance cycles of the transpose buffer; SHALL be >= 1.
REQ-004 Parameter CNT_W, default 8, fill/drain counter width; SHALL satisfy 2^CNT_W > L, where L = 2*DCT_LAT + TRB_LAT.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  1  input sample present this cycle; when low and not draining, the whole pipeline stalls.
REQ-008 flush  input  1  one-cycle request to drain all in-flight samples without new input.
REQ-009 in_ready  output  1  high when an in_valid sample is accepted this cycle; equals (state != DRAIN).
REQ-010 ena1  output  1  advance enable for first 1-D DCT stage.
REQ-011 trb_ena  output  1  advance enable for transpose buffer.
REQ-012 ena2  output  1  advance enable for second 1-D DCT stage.
REQ-013 out_valid  output  1  second-stage output coefficient valid this cycle.
REQ-014 out_sob  output  1  start of block; first coefficient of an NxN block.
REQ-015 out_idx  output  2*log2(N)  raster index of current output coefficient.
REQ-016 busy  output  1  high when state != IDLE.
REQ-017 state  output  2  IDLE=0, FILL=1, RUN=2, DRAIN=3.

Function
REQ-018 advance SHALL be (in_valid AND state != DRAIN) OR (state == DRAIN).
REQ-019 Registered fill counter fc SHALL increment by 1 on every advance cycle while fc < L and SHALL saturate at L.
REQ-020 ena1 SHALL equal advance.
REQ-021 trb_ena SHALL equal advance AND (fc >= DCT_LAT), with fc being the pre-increment value.
REQ-022 ena2 SHALL equal advance AND (fc >= DCT_LAT + TRB_LAT).
REQ-023 out_valid SHALL equal advance AND (fc == L), so a sample accepted at fc=0 emerges exactly L advance cycles later.
REQ-024 All enable and valid outputs SHALL be combinational from registered state/counters and in_valid; a stall cycle forces all of them low in the same cycle.
REQ-025 out_idx SHALL increment on each out_valid cycle and wrap from N*N-1 to 0; out_sob SHALL equal out_valid AND (out_idx == 0).
REQ-026 IDLE -> FILL on in_valid; that sample is accepted (ena1=1) in the same cycle.
REQ-027 FILL -> RUN on the advance cycle in which fc reaches L.
REQ-028 FILL or RUN -> DRAIN on flush=1; a sample presented with in_valid in the flush cycle is accepted, and draining starts the next cycle.
REQ-029 In DRAIN, in_valid SHALL be ignored, every cycle SHALL advance, and drain counter dc SHALL count DRAIN cycles.
REQ-030 DRAIN -> IDLE after exactly L DRAIN cycles; fc, dc and out_idx SHALL be cleared on that transition.
REQ-031 If k samples were accepted (k < L) before flush, exactly k out_valid pulses SHALL occur during DRAIN. If fc was saturated at flush, exactly L pulses SHALL occur.
REQ-032 flush SHALL be ignored in IDLE and in DRAIN.
REQ-033 Block framing SHALL continue across stalls; stalls do not reset out_idx.

Reset
REQ-034 When rst=1 at a clock edge: state=IDLE, fc=0, dc=0, out_idx=0. rst SHALL take priority over in_valid and flush, including mid-FILL, mid-RUN and mid-DRAIN.
REQ-035 During and after reset until the next in_valid: ena1, trb_ena, ena2, out_valid and out_sob=0, busy=0, in_ready=1.

Verification (N=2, DCT_LAT=2, TRB_LAT=3, L=7)
REQ-036 Continuous in_valid from IDLE -> ena1 rises in cycle 0, trb_ena in cycle 2, ena2 in cycle 5, out_valid in cycle 7, and state=RUN from cycle 8.
REQ-037 Continuous in_valid for 20 cycles -> out_sob on every fourth out_valid; out_idx sequence is 0,1,2,3,0.
REQ-038 Drop in_valid for 3 cycles during RUN -> all enables and out_valid are low for exactly those 3 cycles; out_idx and fc are unchanged.
REQ-039 3 samples then flush -> DRAIN for 7 cycles with exactly 3 out_valid pulses, then IDLE with busy=0 and out_idx=0.
REQ-040 in_valid and flush in the same RUN cycle -> that sample is accepted and in_ready=0 next cycle; flush in IDLE -> no state change.
REQ-041 rst asserted mid-DRAIN -> IDLE with all outputs per REQ-035 on the next cycle; a new in_valid restarts the fill from fc=0.
